// File: rtl/regf_wbctl.sv
// rtl/regf_wbctl.sv - register-file write-back arbiter and RAW/WAW scoreboard
module regf_wbctl #(
  parameter int NREG = 16,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic [4:0]      iss_rd,
  input  logic            iss_rd_wen,
  output logic            iss_ready,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            ls_valid,
  input  logic [4:0]      ls_rd,
  input  logic [XLEN-1:0] ls_data,
  output logic            ls_ready,
  output logic            rf_en,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy,
  output logic            wb_err
);

  localparam int         IDXW   = $clog2(NREG);
  localparam logic [5:0] NREG_W = 6'(NREG);

  // x0 and out-of-range indices never take part in hazard tracking.
  function automatic logic is_null(input logic [4:0] idx);
    return (idx == 5'd0) || ({1'b0, idx} >= NREG_W);
  endfunction

  function automatic logic busy_at(input logic [NREG-1:0] vec, input logic [4:0] idx);
    return !is_null(idx) && vec[idx[IDXW-1:0]];
  endfunction

  logic [NREG-1:0] busy_q, busy_d;
  logic            rr_q, rr_d;
  logic            rf_en_q, rf_en_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            wb_err_q, wb_err_d;
  logic            grant;
  logic [4:0]      g_rd;
  logic [XLEN-1:0] g_data;

  always_comb begin
    iss_ready = !flush
                && !busy_at(busy_q, iss_rs1)
                && !busy_at(busy_q, iss_rs2)
                && !(iss_rd_wen && busy_at(busy_q, iss_rd));

    // rr_q high means LS has priority on the next contention.
    ex_ready = ex_valid && (!ls_valid || !rr_q);
    ls_ready = ls_valid && (!ex_valid || rr_q);
    grant    = ex_ready || ls_ready;
    g_rd     = ls_ready ? ls_rd : ex_rd;
    g_data   = ls_ready ? ls_data : ex_data;

    rr_d = rr_q;
    if (ex_ready) begin
      rr_d = 1'b1;
    end else if (ls_ready) begin
      rr_d = 1'b0;
    end

    rf_en_d    = grant && !is_null(g_rd);
    rf_waddr_d = grant ? g_rd : rf_waddr_q;
    rf_wdata_d = grant ? g_data : rf_wdata_q;
    wb_err_d   = wb_err_q || (grant && !is_null(g_rd) && !busy_at(busy_q, g_rd));

    // Clear is applied before set so a same-register collision keeps the set.
    busy_d = flush ? '0 : busy_q;
    if (rf_en_q && !flush) begin
      busy_d[rf_waddr_q[IDXW-1:0]] = 1'b0;
    end
    if (iss_valid && iss_ready && iss_rd_wen && !is_null(iss_rd)) begin
      busy_d[iss_rd[IDXW-1:0]] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      rr_q       <= 1'b0;
      rf_en_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rr_q       <= rr_d;
      rf_en_q    <= rf_en_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign rf_en    = rf_en_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_regf_wbctl.sv
// tb/tb_regf_wbctl.sv - scoreboard bench for regf_wbctl
module tb_regf_wbctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic        iss_rd_wen = 1'b0;
  logic        iss_ready;
  logic        ex_valid = 1'b0, ls_valid = 1'b0;
  logic [4:0]  ex_rd = '0, ls_rd = '0;
  logic [31:0] ex_data = '0, ls_data = '0;
  logic        ex_ready, ls_ready;
  logic        rf_en;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] busy;
  logic        wb_err;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  regf_wbctl #(.NREG(16), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_rd_wen(iss_rd_wen), .iss_ready(iss_ready),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .ls_valid(ls_valid), .ls_rd(ls_rd), .ls_data(ls_data), .ls_ready(ls_ready),
    .rf_en(rf_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wen, input logic exp_rdy, input string nm);
    iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_wen = wen;
    smp();
    chk(nm, 32'(iss_ready), 32'(exp_rdy));
    step();
    iss_valid = 1'b0;
  endtask

  // Monitor: every register-file write must match the next expected write.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (rf_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rf_write_unexpected: got addr %0d data 0x%0h expected no write", rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          if (rf_waddr !== e[36:32] || rf_wdata !== e[31:0]) begin
            errors++;
            $display("FAIL rf_write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                     rf_waddr, rf_wdata, e[36:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    smp();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rf_en", 32'(rf_en), 32'h0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'h0);
    chk("rst_rf_wdata", rf_wdata, 32'h0);
    chk("rst_wb_err", 32'(wb_err), 32'h0);
    chk("rst_iss_ready", 32'(iss_ready), 32'h1);
    step();

    // Basic flow: issue x5, RAW stall, EX write-back, release two cycles later
    issue(0, 0, 5, 1, 1, "iss_rd5");
    iss_valid = 1'b1; iss_rs1 = 5; iss_rs2 = 0; iss_rd = 0; iss_rd_wen = 0;
    ex_valid = 1'b1; ex_rd = 5; ex_data = 32'hDEADBEEF;
    push(5, 32'hDEADBEEF);
    smp();
    chk("busy_x5", 32'(busy), 32'h0020);
    chk("raw_stall_x5", 32'(iss_ready), 32'h0);
    chk("ex_grant_x5", 32'(ex_ready), 32'h1);
    step();
    ex_valid = 1'b0;
    smp();
    chk("raw_stall_wb_cycle", 32'(iss_ready), 32'h0);
    step();
    smp();
    chk("raw_release", 32'(iss_ready), 32'h1);
    chk("busy_after_commit", 32'(busy), 32'h0);
    step();
    iss_valid = 1'b0;

    // Contention (last grant was EX, so LS wins first)
    issue(0, 0, 3, 1, 1, "iss_rd3");
    issue(0, 0, 4, 1, 1, "iss_rd4");
    issue(0, 0, 6, 1, 1, "iss_rd6");
    issue(0, 0, 7, 1, 1, "iss_rd7");
    ex_valid = 1'b1; ex_rd = 3; ex_data = 32'h33;
    ls_valid = 1'b1; ls_rd = 4; ls_data = 32'h44;
    smp();
    chk("busy_3467", 32'(busy), 32'h00D8);
    chk("c1_ex_ready", 32'(ex_ready), 32'h0);
    chk("c1_ls_ready", 32'(ls_ready), 32'h1);
    push(4, 32'h44);
    step();
    ls_rd = 7; ls_data = 32'h77;
    smp();
    chk("c2_ex_ready", 32'(ex_ready), 32'h1);
    chk("c2_ls_ready", 32'(ls_ready), 32'h0);
    chk("c2_rf_en", 32'(rf_en), 32'h1);
    push(3, 32'h33);
    step();
    ex_rd = 6; ex_data = 32'h66;
    smp();
    chk("c3_ex_ready", 32'(ex_ready), 32'h0);
    chk("c3_ls_ready", 32'(ls_ready), 32'h1);
    chk("c3_rf_en", 32'(rf_en), 32'h1);
    push(7, 32'h77);
    step();
    ls_valid = 1'b0;
    smp();
    chk("c4_ex_ready", 32'(ex_ready), 32'h1);
    chk("c4_rf_en", 32'(rf_en), 32'h1);
    push(6, 32'h66);
    step();
    ex_valid = 1'b0;
    smp();
    chk("c5_rf_en", 32'(rf_en), 32'h1);
    step();
    smp();
    chk("busy_drained", 32'(busy), 32'h0);
    step();

    // Null targets
    issue(20, 0, 0, 1, 1, "iss_null_rd0");
    issue(0, 20, 20, 1, 1, "iss_null_rd20");
    ex_valid = 1'b1; ex_rd = 0; ex_data = 32'h1234;
    ls_valid = 1'b1; ls_rd = 20; ls_data = 32'h2020;
    smp();
    chk("null_busy", 32'(busy), 32'h0);
    chk("null_ls_first", 32'(ls_ready), 32'h1);
    chk("null_ex_wait", 32'(ex_ready), 32'h0);
    step();
    ls_valid = 1'b0;
    smp();
    chk("null_ex_grant", 32'(ex_ready), 32'h1);
    chk("null_rf_en_ls", 32'(rf_en), 32'h0);
    step();
    ex_valid = 1'b0;
    smp();
    chk("null_rf_en_ex", 32'(rf_en), 32'h0);
    chk("null_wb_err", 32'(wb_err), 32'h0);
    step();

    // WAW stall and protocol error
    issue(0, 0, 8, 1, 1, "iss_rd8");
    issue(0, 0, 8, 1, 0, "waw_stall_x8");
    issue(8, 0, 0, 0, 0, "raw_stall_x8");
    issue(0, 0, 8, 0, 1, "rd8_no_wen");
    ex_valid = 1'b1; ex_rd = 9; ex_data = 32'h99;
    push(9, 32'h99);
    smp();
    chk("err_ex_grant", 32'(ex_ready), 32'h1);
    chk("err_pre", 32'(wb_err), 32'h0);
    step();
    ex_valid = 1'b0;
    ls_valid = 1'b1; ls_rd = 8; ls_data = 32'h88;
    push(8, 32'h88);
    smp();
    chk("err_set", 32'(wb_err), 32'h1);
    chk("err_ls_grant", 32'(ls_ready), 32'h1);
    step();
    ls_valid = 1'b0;
    step();
    step();
    smp();
    chk("err_sticky", 32'(wb_err), 32'h1);
    chk("err_busy_clear", 32'(busy), 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    smp();
    chk("err_cleared_rst", 32'(wb_err), 32'h0);
    step();

    // Flush
    issue(0, 0, 2, 1, 1, "iss_rd2");
    issue(0, 0, 10, 1, 1, "iss_rd10");
    flush = 1'b1;
    ls_valid = 1'b1; ls_rd = 10; ls_data = 32'hA10;
    iss_valid = 1'b1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 11; iss_rd_wen = 1;
    push(10, 32'hA10);
    smp();
    chk("flush_busy_pre", 32'(busy), 32'h0404);
    chk("flush_iss_reject", 32'(iss_ready), 32'h0);
    chk("flush_ls_grant", 32'(ls_ready), 32'h1);
    step();
    flush = 1'b0; ls_valid = 1'b0; iss_valid = 1'b0;
    smp();
    chk("flush_busy_post", 32'(busy), 32'h0);
    chk("flush_wb_err", 32'(wb_err), 32'h0);
    step();
    smp();
    chk("flush_wb_err_commit", 32'(wb_err), 32'h0);
    chk("flush_busy_final", 32'(busy), 32'h0);
    step();

    // Reset mid-operation: captured write shows once, then pointer back to EX
    issue(0, 0, 12, 1, 1, "iss_rd12");
    ex_valid = 1'b1; ex_rd = 12; ex_data = 32'hC12;
    push(12, 32'hC12);
    smp();
    chk("mid_ex_grant", 32'(ex_ready), 32'h1);
    step();
    ex_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    smp();
    chk("mid_rf_en", 32'(rf_en), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    step();
    issue(0, 0, 1, 1, 1, "iss_rd1");
    issue(0, 0, 2, 1, 1, "iss_rd2b");
    ex_valid = 1'b1; ex_rd = 1; ex_data = 32'h111;
    ls_valid = 1'b1; ls_rd = 2; ls_data = 32'h222;
    push(1, 32'h111);
    smp();
    chk("rr_reset_ex", 32'(ex_ready), 32'h1);
    chk("rr_reset_ls", 32'(ls_ready), 32'h0);
    step();
    ex_valid = 1'b0;
    push(2, 32'h222);
    smp();
    chk("rr_reset_ls2", 32'(ls_ready), 32'h1);
    step();
    ls_valid = 1'b0;
    step();
    step();
    smp();
    chk("end_busy", 32'(busy), 32'h0);
    chk("end_wb_err", 32'(wb_err), 32'h0);
    chk("end_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
